// File: rtl/fv_bank_streamer_pkg.sv
// Shared types and default dimensions for the feature-value bank streamer.
package fv_bank_streamer_pkg;

  localparam int FV_SIZE     = 16;
  localparam int MAX_FV_NUM  = 16;
  localparam int MAX_NODE_ID = 256;
  localparam int NODE_W      = $clog2(MAX_NODE_ID);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic                    sos;
    logic                    eos;
    logic [1:0][FV_SIZE-1:0] fv_data;
    logic [NODE_W-1:0]       node_id;
  } bank2rs_t;

endpackage

// File: rtl/fv_req_fifo.sv
// Small request FIFO with occupancy count; pushes when full are dropped.
module fv_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fv_bank_streamer.sv
// Pops node requests, reads each node's FV words two per beat and streams them
// to the RS with sos/eos framing, two cycles behind the read strobe.
module fv_bank_streamer #(
  parameter int FV_SIZE     = fv_bank_streamer_pkg::FV_SIZE,
  parameter int MAX_FV_NUM  = fv_bank_streamer_pkg::MAX_FV_NUM,
  parameter int MAX_NODE_ID = fv_bank_streamer_pkg::MAX_NODE_ID,
  parameter int REQ_DEPTH   = 4
) (
  input  logic                                                   clk,
  input  logic                                                   reset_n,
  input  logic                                                   req_valid,
  input  logic [$clog2(MAX_NODE_ID)-1:0]                         req_node_id,
  output logic                                                   req_ready,
  input  logic [$clog2(MAX_FV_NUM):0]                            num_fv,
  input  logic                                                   RS_available,
  output logic                                                   mem_rd_en,
  output logic [$clog2(MAX_NODE_ID)+$clog2(MAX_FV_NUM/2)-1:0]    mem_rd_addr,
  input  logic [2*FV_SIZE-1:0]                                   mem_rd_data,
  output logic                                                   Bank2RS_sos,
  output logic                                                   Bank2RS_eos,
  output logic [FV_SIZE-1:0]                                     Bank2RS_FV_data_0,
  output logic [FV_SIZE-1:0]                                     Bank2RS_FV_data_1,
  output logic [$clog2(MAX_NODE_ID)-1:0]                         Bank2RS_Node_id,
  output logic                                                   busy
);

  import fv_bank_streamer_pkg::*;

  localparam int ID_W    = $clog2(MAX_NODE_ID);
  localparam int BEAT_W  = $clog2(MAX_FV_NUM / 2);
  localparam int NUMFV_W = $clog2(MAX_FV_NUM) + 1;
  localparam int CNT_W   = $clog2(REQ_DEPTH + 1);

  state_t             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [ID_W-1:0]    node_q, node_d;
  logic               fifo_pop;
  logic [ID_W-1:0]    fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [NUMFV_W-1:0] nf_clamped;
  logic [NUMFV_W-1:0] nbeats;
  logic [BEAT_W-1:0]  last_beat;
  logic [ID_W-1:0]    rd_node;
  logic [BEAT_W-1:0]  rd_beat;
  logic               rd_first;
  logic               rd_last;
  logic               s1_valid, s1_sos, s1_eos;
  bank2rs_t           out_q;

  fv_req_fifo #(
    .WIDTH (ID_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (req_valid),
    .push_data (req_node_id),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

  assign fifo_empty = (fifo_count == '0);
  assign req_ready  = (fifo_count < CNT_W'(REQ_DEPTH));
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

  // Clamp to [4, MAX_FV_NUM], then round odd counts up to a whole beat.
  always_comb begin
    if (num_fv < NUMFV_W'(4))                nf_clamped = NUMFV_W'(4);
    else if (num_fv > NUMFV_W'(MAX_FV_NUM))  nf_clamped = NUMFV_W'(MAX_FV_NUM);
    else                                     nf_clamped = num_fv;
    nbeats    = (nf_clamped >> 1) + {{(NUMFV_W-1){1'b0}}, nf_clamped[0]};
    last_beat = BEAT_W'(nbeats - NUMFV_W'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      node_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      node_q  <= node_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    node_d    = node_q;
    fifo_pop  = 1'b0;
    mem_rd_en = 1'b0;
    rd_node   = node_q;
    rd_beat   = '0;
    rd_first  = 1'b0;
    rd_last   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && RS_available) begin
          fifo_pop  = 1'b1;
          node_d    = fifo_head;
          rd_node   = fifo_head;
          mem_rd_en = 1'b1;
          rd_first  = 1'b1;
          beat_d    = BEAT_W'(1);
          state_d   = S_READ;
        end
      end
      S_READ: begin
        mem_rd_en = 1'b1;
        rd_beat   = beat_q;
        rd_last   = (beat_q == last_beat);
        if (rd_last) begin
          beat_d  = '0;
          state_d = S_DRAIN;
        end else begin
          beat_d  = beat_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_q.eos) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_rd_addr = {rd_node, rd_beat};

  // Stage 1 tracks the word in flight from memory; stage 2 registers it out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_sos   <= 1'b0;
      s1_eos   <= 1'b0;
      out_q    <= '0;
    end else begin
      s1_valid         <= mem_rd_en;
      s1_sos           <= rd_first;
      s1_eos           <= rd_last;
      out_q.sos        <= s1_valid && s1_sos;
      out_q.eos        <= s1_valid && s1_eos;
      out_q.fv_data[0] <= s1_valid ? mem_rd_data[FV_SIZE-1:0] : '0;
      out_q.fv_data[1] <= s1_valid ? mem_rd_data[2*FV_SIZE-1:FV_SIZE] : '0;
      out_q.node_id    <= s1_valid ? node_q : '0;
    end
  end

  assign Bank2RS_sos       = out_q.sos;
  assign Bank2RS_eos       = out_q.eos;
  assign Bank2RS_FV_data_0 = out_q.fv_data[0];
  assign Bank2RS_FV_data_1 = out_q.fv_data[1];
  assign Bank2RS_Node_id   = out_q.node_id;

endmodule
